// File: rtl/match_job_arbiter.sv
// ============================================================================
// Module   : match_job_arbiter
// Brief    : Round-robin arbiter sharing one string-match engine among job
//            sources; routes in-order engine results back to job owners.
//            Optional MATCH_ARB_STATS_EN adds per-requester job counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_job_arbiter #(
    parameter int NUM_REQUESTERS   = 2,
    parameter int OWNER_FIFO_DEPTH = 4,
    localparam int ID_W            = $clog2(NUM_REQUESTERS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [8*NUM_REQUESTERS-1:0]   req_data,
    input  logic [NUM_REQUESTERS-1:0]     req_valid,
    input  logic [NUM_REQUESTERS-1:0]     req_last,
    output logic [NUM_REQUESTERS-1:0]     req_ready,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [ID_W-1:0]               out_source,
    input  logic                          res_valid,
    input  logic                          res_match,
    output logic [NUM_REQUESTERS-1:0]     req_res_valid,
    output logic                          req_res_match,
    output logic                          err_orphan
`ifdef MATCH_ARB_STATS_EN
    ,
    output logic [16*NUM_REQUESTERS-1:0]  job_count
`endif
);

    localparam int c_PTR_W = $clog2(OWNER_FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(OWNER_FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_fifo [OWNER_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_pick_found;
    logic [ID_W-1:0]     w_pick_id;
    logic [ID_W-1:0]     w_scan_idx;
    logic [7:0]          w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [ID_W-1:0]     w_rr_next;

    // Scan downward so the lowest offset from rr_ptr is the final winner.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_scan_idx   = '0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQUESTERS);
            if (req_valid[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_data  = req_data[8*i +: 8];
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_GRANTED) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    assign w_accept  = (r_state == ST_GRANTED) && w_sel_valid;
    assign w_push    = w_accept && w_sel_last;
    assign w_full    = (r_count == c_CNT_W'(OWNER_FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = res_valid && !w_empty;
    assign w_rr_next = (r_grant == ID_W'(NUM_REQUESTERS - 1)) ? '0 : r_grant + ID_W'(1);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_source    <= '0;
            req_res_valid <= '0;
            req_res_match <= 1'b0;
            err_orphan    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found && !w_full) begin
                        r_grant <= w_pick_id;
                        r_state <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (w_push) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            out_valid  <= w_accept;
            out_data   <= w_accept ? w_sel_data : '0;
            out_last   <= w_accept && w_sel_last;
            out_source <= w_accept ? r_grant : '0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            // Push and pop together leave occupancy unchanged, even when full.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            req_res_valid <= '0;
            if (w_pop) begin
                req_res_valid[r_fifo[r_rd_ptr]] <= 1'b1;
            end
            req_res_match <= w_pop && res_match;
            err_orphan    <= err_orphan || (res_valid && w_empty);
        end
    end

`ifdef MATCH_ARB_STATS_EN
    logic [15:0] r_job_count [NUM_REQUESTERS];

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_stats
        always_ff @(posedge clock) begin
            if (reset) begin
                r_job_count[g] <= '0;
            end else if (w_push && (r_grant == ID_W'(g)) && (r_job_count[g] != 16'hFFFF)) begin
                r_job_count[g] <= r_job_count[g] + 16'd1;
            end
        end
        assign job_count[16*g +: 16] = r_job_count[g];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_match_job_arbiter.sv
// ============================================================================
// Module   : tb_match_job_arbiter
// Brief    : Self-checking bench for match_job_arbiter with a queue-based
//            reference model plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_job_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int ID_W  = $clog2(N);

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [8*N-1:0]      req_data = '0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_last = '0;
    logic [N-1:0]        req_ready;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_last;
    logic [ID_W-1:0]     out_source;
    logic                res_valid = 1'b0;
    logic                res_match = 1'b0;
    logic [N-1:0]        req_res_valid;
    logic                req_res_match;
    logic                err_orphan;
`ifdef MATCH_ARB_STATS_EN
    logic [16*N-1:0]     job_count;
`endif

    always #5 clock = ~clock;

    match_job_arbiter #(
        .NUM_REQUESTERS   (N),
        .OWNER_FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_source    (out_source),
        .res_valid     (res_valid),
        .res_match     (res_match),
        .req_res_valid (req_res_valid),
        .req_res_match (req_res_match),
        .err_orphan    (err_orphan)
`ifdef MATCH_ARB_STATS_EN
        ,
        .job_count     (job_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who owns the engine, round-robin start, owner queue.
    bit          m_init = 1'b0;
    bit          m_busy;
    int          m_owner;
    int          m_rr;
    int          m_q[$];
    int          m_jobs[N];
    bit          e_ov, e_ol, e_rm, e_orph;
    logic [7:0]  e_od;
    int          e_os;
    logic [N-1:0] e_rv;

    task automatic model_step();
        int pre_size;
        bit acc;
        if (reset) begin
            m_init = 1'b1; m_busy = 1'b0; m_owner = 0; m_rr = 0; m_q.delete();
            e_ov = 0; e_ol = 0; e_od = '0; e_os = 0; e_rv = '0; e_rm = 0; e_orph = 0;
            for (int r = 0; r < N; r++) m_jobs[r] = 0;
            return;
        end
        pre_size = m_q.size();
        acc  = m_busy && req_valid[m_owner];
        e_ov = acc;
        e_od = req_data[8*m_owner +: 8];
        e_ol = acc && req_last[m_owner];
        e_os = m_owner;
        e_rv = '0;
        e_rm = 1'b0;
        if (res_valid) begin
            if (pre_size > 0) begin
                e_rv[m_q.pop_front()] = 1'b1;
                e_rm = res_match;
            end else begin
                e_orph = 1'b1;
            end
        end
        if (m_busy) begin
            if (acc && req_last[m_owner]) begin
                m_q.push_back(m_owner);
                if (m_jobs[m_owner] < 65535) m_jobs[m_owner]++;
                m_rr   = (m_owner + 1) % N;
                m_busy = 1'b0;
            end
        end else if (pre_size < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && req_valid[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    m_busy  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (m_init) begin
                logic [N-1:0] exp_rdy;
                exp_rdy = m_busy ? (N'(1) << m_owner) : '0;
                check("req_ready", req_ready, exp_rdy);
                check("out_valid", out_valid, e_ov);
                if (e_ov) begin
                    check("out_data", out_data, e_od);
                    check("out_last", out_last, e_ol);
                    check("out_source", out_source, e_os);
                end
                check("req_res_valid", req_res_valid, e_rv);
                check("req_res_match", req_res_match, e_rm);
                check("err_orphan", err_orphan, e_orph);
`ifdef MATCH_ARB_STATS_EN
                for (int r = 0; r < N; r++) check("job_count", job_count[16*r +: 16], m_jobs[r]);
`endif
            end
            model_step();
        end
    end

    // Requester-side bookkeeping for stimulus generation.
    int d_pos[N];
    int d_len[N];
    int jobs_done[$];

    task automatic run(input int cycles, input logic [N-1:0] mask, input int vprob,
                       input int rprob, input int lmin, input int lmax, input int rstp);
        for (int c = 0; c < cycles; c++) begin
            logic [N-1:0] acc;
            for (int r = 0; r < N; r++) begin
                if (d_len[r] == 0) begin
                    d_len[r] = int'($urandom_range(lmax, lmin));
                    d_pos[r] = 0;
                end
                req_valid[r]        = mask[r] && (int'($urandom_range(99, 0)) < vprob);
                req_data[8*r +: 8]  = 8'($urandom);
                req_last[r]         = (d_pos[r] == d_len[r] - 1);
            end
            res_valid = int'($urandom_range(99, 0)) < rprob;
            res_match = 1'($urandom);
            reset     = int'($urandom_range(999, 0)) < rstp;
            acc = req_valid & req_ready;
            for (int r = 0; r < N; r++) begin
                if (reset) d_pos[r] = 0;
                else if (acc[r]) begin
                    if (req_last[r]) begin
                        jobs_done.push_back(r);
                        d_len[r] = 0;
                    end else begin
                        d_pos[r]++;
                    end
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; req_last = '0; res_valid = 1'b0; res_match = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int r = 0; r < N; r++) begin d_pos[r] = 0; d_len[r] = 0; end
        jobs_done.delete();
    endtask

    task automatic pulse_result(input logic m);
        reset = 1'b0; req_valid = '0; res_valid = 1'b1; res_match = m;
        @(posedge clock); #1;
        res_valid = 1'b0; res_match = 1'b0;
    endtask

    initial begin
        int exp_rr[4];
        exp_rr = '{0, 1, 0, 1};

        // Single 8-byte job from requester 0
        apply_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", req_res_valid, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_out_source", out_source, 0);
        run(9, 2'b01, 100, 0, 8, 8, 0);
        check("single_jobs", jobs_done.size(), 1);
        check("single_out_valid", out_valid, 1);
        check("single_out_last", out_last, 1);
        check("single_out_source", out_source, 0);
        check("single_ready_idle", req_ready, 0);
        pulse_result(1'b1);
        check("single_res_valid", req_res_valid, 2'b01);
        check("single_res_match", req_res_match, 1);

        // Round robin with 2-byte jobs, then FIFO full stall
        apply_reset();
        run(12, 2'b11, 100, 0, 2, 2, 0);
        check("rr_jobs", jobs_done.size(), 4);
        for (int i = 0; i < 4 && i < jobs_done.size(); i++) check("rr_order", jobs_done[i], exp_rr[i]);
        run(6, 2'b11, 100, 0, 2, 2, 0);
        check("full_no_grant_jobs", jobs_done.size(), 4);
        check("full_ready", req_ready, 0);
        run(1, 2'b11, 100, 100, 2, 2, 0);
        check("full_pop_res", req_res_valid, 2'b01);
        check("full_pop_ready", req_ready, 0);
        run(1, 2'b11, 100, 0, 2, 2, 0);
        check("full_resume_ready", req_ready, 2'b01);

        // Orphan result
        apply_reset();
        pulse_result(1'b1);
        check("orphan_res_valid", req_res_valid, 0);
        check("orphan_res_match", req_res_match, 0);
        check("orphan_flag", err_orphan, 1);
        run(5, 2'b00, 0, 0, 1, 1, 0);
        check("orphan_sticky", err_orphan, 1);
        apply_reset();
        check("orphan_cleared", err_orphan, 0);

        // Reset mid-job, then requester 1 job
        run(4, 2'b01, 100, 0, 8, 8, 0);
        check("midjob_out_valid", out_valid, 1);
        apply_reset();
        check("midjob_rst_valid", out_valid, 0);
        check("midjob_rst_ready", req_ready, 0);
        check("midjob_rst_data", out_data, 0);
        run(3, 2'b10, 100, 0, 2, 2, 0);
        check("midjob_jobs", jobs_done.size(), 1);
        check("midjob_out_source", out_source, 1);
        check("midjob_out_last", out_last, 1);
        pulse_result(1'b1);
        check("midjob_res_valid", req_res_valid, 2'b10);
        check("midjob_res_match", req_res_match, 1);
        run(6, 2'b10, 100, 0, 2, 2, 0);
`ifdef MATCH_ARB_STATS_EN
        check("stats_r1", job_count[31:16], 3);
        check("stats_r0", job_count[15:0], 0);
`endif

        // Randomised traffic against the model
        apply_reset();
        run(3000, '1, 70, 30, 1, 6, 2);
        run(2000, '1, 90, 8, 1, 3, 1);
        run(1000, '1, 50, 60, 1, 4, 0);

        @(posedge clock); #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/match_job_arbiter.md
MATCH_JOB_ARBITER -- requirements
Module: match_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 2, meaning number of job sources sharing one string-match engine (legal range 2..8).
REQ-002 SHALL have parameter OWNER_FIFO_DEPTH, default 4, meaning the number of outstanding jobs whose results are pending (power of two, 2..16).
REQ-003 SHALL define ID_W = $clog2(NUM_REQUESTERS) for internal and output ID width.
REQ-004 clock  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_data  input  8*NUM_REQUESTERS  per-requester job byte; requester i occupies bits [8i+7:8i].
REQ-007 req_valid  input  NUM_REQUESTERS  per-requester byte valid.
REQ-008 req_last  input  NUM_REQUESTERS  per-requester last byte of job (needle bytes followed by haystack bytes).
REQ-009 req_ready  output  NUM_REQUESTERS  per-requester byte accept; combinational from registered state only.
REQ-010 out_data  output  8  byte to match engine.
REQ-011 out_valid  output  1  out_data valid; engine applies no backpressure.
REQ-012 out_last  output  1  last byte of job.
REQ-013 out_source  output  ID_W  ID of the requester currently driving out_*.
REQ-014 res_valid  input  1  engine result strobe, one per completed job, in job order.
REQ-015 res_match  input  1  engine result: 1 = needle found.
REQ-016 req_res_valid  output  NUM_REQUESTERS  result strobe routed to job owner.
REQ-017 req_res_match  output  1  result value accompanying req_res_valid.
REQ-018 err_orphan  output  1  sticky flag: res_valid arrived with no outstanding job.

Function
REQ-019 SHALL implement two states: IDLE and GRANTED.
REQ-020 In IDLE, when any req_valid is high and the owner FIFO is not full, SHALL select the first requester with req_valid high searching upward (wrapping) from rr_ptr, register it as grant, and enter GRANTED next cycle.
REQ-021 In IDLE, req_ready SHALL be all zero; no grant SHALL be made while the owner FIFO is full.
REQ-022 In GRANTED, req_ready[grant] SHALL be 1 and all other bits 0.
REQ-023 A byte SHALL be accepted when req_valid[grant] and req_ready[grant] are both high.
REQ-024 Each accepted byte SHALL appear on out_data/out_valid/out_last/out_source exactly one cycle later; out_valid SHALL be 0 in cycles following no acceptance.
REQ-025 On acceptance of a byte with req_last high: SHALL push grant into the owner FIFO, set rr_ptr to grant+1 (wrapping at NUM_REQUESTERS), and return to IDLE next cycle.
REQ-026 A granted job SHALL never be interrupted; gaps in req_valid[grant] SHALL hold GRANTED indefinitely.
REQ-027 On res_valid with FIFO non-empty: SHALL pop head ID h and, one cycle later, pulse req_res_valid[h]=1 for one cycle with req_res_match = registered res_match.
REQ-028 On res_valid with FIFO empty: SHALL drop the result, keep req_res_valid zero, and set err_orphan until reset.
REQ-029 Simultaneous push and pop SHALL both take effect, including when the FIFO is full; occupancy unchanged.
REQ-030 FIFO pointers SHALL wrap modulo OWNER_FIFO_DEPTH; occupancy counter width $clog2(OWNER_FIFO_DEPTH+1).
REQ-031 req_res_match SHALL be 0 whenever req_res_valid is all zero.

Reset
REQ-032 Reset SHALL set state IDLE, grant 0, rr_ptr 0, FIFO empty, and all outputs (out_*, req_res_valid, req_res_match, err_orphan) to 0.
REQ-033 Reset mid-job SHALL discard the partial job and all pending owner entries; req_ready SHALL be 0 in the cycle after reset is sampled.

Configuration
REQ-034 Macro MATCH_ARB_STATS_EN SHALL, when defined, add output job_count (16*NUM_REQUESTERS): per-requester count of completed jobs (push events), saturating at 16'hFFFF, reset to 0.
REQ-035 Without MATCH_ARB_STATS_EN the job_count port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-036 Single job: requester 0 sends 5 needle + 3 haystack bytes (last on byte 8) -> out_* reproduces 8 bytes, 1-cycle lag, out_source=0, out_last on 8th; res_valid,res_match=1 -> req_res_valid=2'b01, req_res_match=1.
REQ-037 Round robin: both requesters continuously valid with 2-byte jobs -> grants alternate 0,1,0,1; out_source follows.
REQ-038 FIFO full: 4 jobs complete with no res_valid -> no fifth grant (req_ready=0) until one res_valid, then grant resumes one cycle after pop.
REQ-039 Orphan: res_valid with empty FIFO -> req_res_valid stays 0, err_orphan=1 until reset.
REQ-040 Reset after 3 bytes of a job -> all outputs 0; new job from requester 1 is granted first and routed correctly.
REQ-041 With MATCH_ARB_STATS_EN: 3 jobs from requester 1 -> job_count[31:16]=3, job_count[15:0]=0.
